instr_reader_exec: RTL and testbench

- Consumer side of the instruction register: the block that reads back what the writer stored.
- On a start request it walks a contiguous window of register locations via read_pointer and captures each instruction_word.
- For each word it evaluates opcode on operand_a/operand_b and presents a signed result on a valid/ready output channel.
- It sits between the instruction register and downstream result checking or storage logic.

---
 rtl/instr_reader_exec.sv | 207 ++++++++++++++++++++
 tb/tb_instr_reader_exec.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reader_exec.sv
// instr_reader_exec
//   Reads back a contiguous window of the instruction register, evaluates
//   each {opc, op_a, op_b} word, and presents a signed result on a
//   valid/ready output channel.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start              one-cycle run request, only looked at in IDLE
//   first_ptr, count   first location and number of locations (1..32)
//   read_pointer       address to the instruction register
//   instruction_word   {opc, op_a, op_b}, asynchronous read of read_pointer
//   busy, done         run in progress / one-cycle end-of-run pulse
//   res_valid/ready    result handshake
//   result, res_addr   signed result and the location it came from
//   res_opc, res_err   opcode of the result, illegal opcode or /0, %0
//   dbg_state          current FSM state (IDLE=0 FETCH=1 EXEC=2 OUT=3)
//
// Handshake: a result transfers on every rising edge where res_valid and
// res_ready are both high. Once res_valid is raised, result, res_addr,
// res_opc and res_err stay constant until that transfer; res_valid never
// drops without a transfer (except on reset).
module instr_reader_exec #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int OPC_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         first_ptr,
  input  logic [ADDR_W:0]           count,
  output logic [ADDR_W-1:0]         read_pointer,
  input  logic [OPC_W+2*OP_W-1:0]   instruction_word,
  output logic                      busy,
  output logic                      done,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*OP_W-1:0]         result,
  output logic [ADDR_W-1:0]         res_addr,
  output logic [OPC_W-1:0]          res_opc,
  output logic                      res_err,
  output logic [1:0]                dbg_state
);

  localparam int RW = 2 * OP_W;

  localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [RW-1:0]       result_q, result_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OPC_W-1:0]    ropc_q, ropc_d;
  logic                err_q, err_d;
  // Holding registers for the fetched word.
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;

  // Operands widened to the result width before any operation, so the
  // product is exact and INT_MIN / -1 does not overflow.
  logic signed [RW-1:0] a_ext, b_ext;
  logic        [RW-1:0] alu_res;
  logic                 alu_err;

  assign a_ext = {{OP_W{a_q[OP_W-1]}}, a_q};
  assign b_ext = {{OP_W{b_q[OP_W-1]}}, b_q};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opc_q)
      OPC_ZERO:  alu_res = '0;
      OPC_PASSA: alu_res = a_ext;
      OPC_PASSB: alu_res = b_ext;
      OPC_ADD:   alu_res = a_ext + b_ext;
      OPC_SUB:   alu_res = a_ext - b_ext;
      OPC_MULT:  alu_res = a_ext * b_ext;
      OPC_DIV: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext % b_ext;
      end
      default:   alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rp_d     = rp_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    result_d = result_q;
    addr_d   = addr_q;
    ropc_d   = ropc_q;
    err_d    = err_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      S_IDLE: begin
        if (start && (count != '0)) begin
          rp_d    = first_ptr;
          rem_d   = count;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        opc_d   = instruction_word[OPC_W+2*OP_W-1 -: OPC_W];
        a_d     = instruction_word[2*OP_W-1 -: OP_W];
        b_d     = instruction_word[OP_W-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        addr_d   = rp_q;
        ropc_d   = opc_q;
        err_d    = alu_err;
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (valid_q && res_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // Natural wrap of the ADDR_W-bit pointer.
            rp_d    = rp_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rp_q     <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      ropc_q   <= '0;
      err_q    <= 1'b0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      rp_q     <= rp_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      ropc_q   <= ropc_d;
      err_q    <= err_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign read_pointer = rp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign res_valid    = valid_q;
  assign result       = result_q;
  assign res_addr     = addr_q;
  assign res_opc      = ropc_q;
  assign res_err      = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_reader_exec.sv
// Bench for instr_reader_exec: a behavioural instruction register, a result
// scoreboard fed when each run is launched, and directed plus random runs.
module tb_instr_reader_exec;

  localparam int ADDR_W = 5;
  localparam int OP_W   = 32;
  localparam int OPC_W  = 4;
  localparam int WW     = OPC_W + 2*OP_W;
  localparam int RW     = 2*OP_W;
  localparam int EW     = ADDR_W + OPC_W + 1 + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   first_ptr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W-1:0]   read_pointer;
  logic [WW-1:0]       instruction_word;
  logic                busy, done, res_valid, res_ready, res_err;
  logic [RW-1:0]       result;
  logic [ADDR_W-1:0]   res_addr;
  logic [OPC_W-1:0]    res_opc;
  logic [1:0]          dbg_state;

  logic [WW-1:0] mem [32];
  assign instruction_word = mem[read_pointer];

  instr_reader_exec dut (
    .clk(clk), .reset(reset), .start(start), .first_ptr(first_ptr),
    .count(count), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .res_addr(res_addr), .res_opc(res_opc), .res_err(res_err),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [EW-1:0] got,
                          input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [3:0] o,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    return {o, a, b};
  endfunction

  // Reference arithmetic: returns {err, result}.
  function automatic logic [RW:0] model(input logic [WW-1:0] w);
    longint a, b;
    logic [3:0] o;
    o = w[67:64];
    a = longint'($signed(w[63:32]));
    b = longint'($signed(w[31:0]));
    case (o)
      4'd0: return {1'b0, 64'd0};
      4'd1: return {1'b0, a};
      4'd2: return {1'b0, b};
      4'd3: return {1'b0, a + b};
      4'd4: return {1'b0, a - b};
      4'd5: return {1'b0, a * b};
      4'd6: if (b == 0) return {1'b1, 64'd0}; else return {1'b0, a / b};
      4'd7: if (b == 0) return {1'b1, 64'd0}; else return {1'b0, a % b};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic push_exp(input logic [4:0] ad, input logic [3:0] o,
                          input logic [63:0] r, input logic e);
    exp_q.push_back({ad, o, e, r});
  endtask

  task automatic push_model(input logic [4:0] fp, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [4:0]  ad;
      logic [RW:0] r;
      ad = 5'(fp + i);
      r  = model(mem[ad]);
      push_exp(ad, mem[ad][67:64], r[63:0], r[64]);
    end
  endtask

  // ---------------- monitor ----------------
  logic          stall_q = 1'b0;
  logic [RW-1:0] p_res;
  logic [4:0]    p_addr, p_rp;

  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check_eq("stall_valid", res_valid, 1);
        check_eq("stall_result", result, p_res);
        check_eq("stall_addr", res_addr, p_addr);
        check_eq("stall_rptr", read_pointer, p_rp);
      end
      if (res_valid && !res_ready) begin
        stall_q = 1'b1;
        p_res = result; p_addr = res_addr; p_rp = read_pointer;
      end else begin
        stall_q = 1'b0;
      end
      if (res_valid && res_ready) begin
        check_eq("queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check_eq("result_tuple", {res_addr, res_opc, res_err, result}, e);
          check_eq("rptr_at_hs", read_pointer, res_addr);
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  // mode 0: ready always high; 1: random ready; 2: ready low for the first
  // 5 cycles of each valid result, then high.
  task automatic do_run(input logic [4:0] fp, input logic [5:0] cnt,
                        input int mode, input bit disturb, input bit chk_lat);
    int  dc0, hold;
    bit  seen, lat_done;
    dc0 = done_cnt; hold = 0; seen = 0; lat_done = 0;
    @(posedge clk); #1;
    first_ptr = fp; count = cnt; start = 1'b1;
    res_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check_eq("busy_in_run", busy, 1);
      // Result visible in the third cycle counted from the accepting edge.
      if (chk_lat && !lat_done && res_valid) begin
        check_eq("first_latency", cyc, 3);
        lat_done = 1;
      end
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
      if (mode == 1) res_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (res_valid && hold < 5) begin res_ready = 1'b0; hold++; end
        else if (hold >= 5) begin res_ready = 1'b1; if (!res_valid) hold = 0; end
      end
      if (disturb && cyc == 4) begin
        start = 1'b1; first_ptr = 5'd10; count = 6'd7;
      end else begin
        start = 1'b0;
      end
    end
    check_eq("done_seen", seen, 1);
    start = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("done_count", done_cnt - dc0, 1);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    bit got_valid;
    logic [4:0] rfp;
    logic [5:0] rcnt;
    reset = 1'b0; start = 1'b0; first_ptr = '0; count = '0; res_ready = 1'b0;
    for (int i = 0; i < 32; i++)
      mem[i] = mk(4'($urandom_range(0, 10)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
    mem[0] = mk(4'd3, 32'd5, 32'd3);
    mem[1] = mk(4'd4, 32'd2, 32'd7);
    mem[2] = mk(4'd5, 32'hFFFF_FFFC, 32'd6);
    mem[4] = mk(4'd6, 32'd7, 32'd0);
    mem[5] = mk(4'd6, 32'hFFFF_FFF9, 32'd2);
    mem[6] = mk(4'd7, 32'hFFFF_FFF9, 32'd2);
    mem[7] = mk(4'd5, 32'h7FFF_FFFF, 32'd2);
    mem[8] = mk(4'd9, 32'd3, 32'd4);

    #1 reset = 1'b1;
    #1 check_eq("reset_async", {read_pointer, busy, done, res_valid, result,
                                res_addr, res_opc, res_err}, '0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_state", {busy, res_valid, read_pointer, dbg_state}, '0);

    // Basic run with first-result latency.
    push_exp(5'd0, 4'd3, 64'd8, 1'b0);
    push_exp(5'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    push_exp(5'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFE8, 1'b0);
    do_run(5'd0, 6'd3, 0, 1'b0, 1'b1);
    check_eq("rptr_holds", read_pointer, 5'd2);

    // Wrap across the top of the register.
    push_model(5'd30, 4);
    do_run(5'd30, 6'd4, 0, 1'b0, 1'b0);
    check_eq("wrap_rptr_end", read_pointer, 5'd1);

    // Backpressure.
    push_model(5'd10, 3);
    do_run(5'd10, 6'd3, 2, 1'b0, 1'b0);

    // Arithmetic edges, with a start pulsed mid-run.
    push_exp(5'd4, 4'd6, 64'd0, 1'b1);
    push_exp(5'd5, 4'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    push_exp(5'd6, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_exp(5'd7, 4'd5, 64'h0000_0000_FFFF_FFFE, 1'b0);
    push_exp(5'd8, 4'd9, 64'd0, 1'b1);
    do_run(5'd4, 6'd5, 0, 1'b1, 1'b0);

    // start with count=0 is ignored.
    dc = done_cnt;
    @(posedge clk); #1 first_ptr = 5'd3; count = 6'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("zero_cnt_busy", busy, 0);
    end
    check_eq("zero_cnt_done", done_cnt - dc, 0);

    // Reset while a result is waiting.
    dc = done_cnt;
    @(posedge clk); #1 first_ptr = 5'd12; count = 6'd2; start = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    got_valid = 0;
    for (int i = 0; i < 10 && !got_valid; i++) begin
      @(negedge clk);
      got_valid = res_valid;
    end
    check_eq("pre_reset_valid", got_valid, 1);
    #2 reset = 1'b1;
    #1 check_eq("midrun_reset_async", {read_pointer, busy, done, res_valid, result,
                                      res_addr, res_opc, res_err}, '0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("no_done_on_reset", done_cnt - dc, 0);
    push_exp(5'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFE8, 1'b0);
    do_run(5'd2, 6'd1, 0, 1'b0, 1'b0);

    // Random window with random backpressure.
    rfp  = 5'($urandom_range(0, 31));
    rcnt = 6'($urandom_range(1, 32));
    push_model(rfp, int'(rcnt));
    do_run(rfp, rcnt, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
